// File: rtl/mcu_core_p.sv
// Parametrised multi-cycle microcontroller core: 16-opcode ISA, Z/C flags,
// conditional branches, valid-handshake instruction fetch and a strobed I/O port.
module mcu_core_p #(
  parameter  int unsigned DW  = 8,
  parameter  int unsigned RAW = 4,
  parameter  int unsigned PCW = 4,
  localparam int unsigned IW  = 4 + RAW + DW
) (
  input  logic           clk,
  input  logic           reset,
  output logic [PCW-1:0] imem_addr,
  output logic           imem_rd,
  input  logic [IW-1:0]  imem_data,
  input  logic           imem_valid,
  input  logic [DW-1:0]  io_in,
  output logic [DW-1:0]  io_out,
  output logic           io_out_valid,
  output logic           flag_z,
  output logic           flag_c,
  output logic           halted
);

  localparam int unsigned NREG = 1 << RAW;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_IN   = 4'h6;
  localparam logic [3:0] OP_OUT  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_ADDR = 4'hB;
  localparam logic [3:0] OP_SHL  = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t          state, state_nxt;
  logic [PCW-1:0]  pc, pc_nxt;
  logic [IW-1:0]   ir;
  logic [DW-1:0]   regs [NREG];
  logic            ir_ld, wr_en, out_ld, upd_z;
  logic [DW-1:0]   wr_data;
  logic            z_nxt, c_nxt;
  logic [DW:0]     ext;

  logic [3:0]      op;
  logic [RAW-1:0]  rd_idx;
  logic [DW-1:0]   imm, rval, sval;

  assign op        = ir[IW-1 -: 4];
  assign rd_idx    = ir[DW +: RAW];
  assign imm       = ir[DW-1:0];
  assign rval      = regs[rd_idx];
  assign sval      = regs[imm[RAW-1:0]];
  assign imem_addr = pc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next state, execute datapath and flag computation
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_ld     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = rval;
    out_ld    = 1'b0;
    upd_z     = 1'b0;
    z_nxt     = flag_z;
    c_nxt     = flag_c;
    ext       = '0;
    case (state)
      S_FETCH: begin
        if (imem_rd && imem_valid) begin
          ir_ld     = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc + PCW'(1);
        case (op)
          OP_ADD:  begin ext = {1'b0, rval} + {1'b0, imm}; wr_data = ext[DW-1:0]; c_nxt = ext[DW]; wr_en = 1'b1; upd_z = 1'b1; end
          OP_SUB:  begin ext = {1'b0, rval} - {1'b0, imm}; wr_data = ext[DW-1:0]; c_nxt = ext[DW]; wr_en = 1'b1; upd_z = 1'b1; end
          OP_AND:  begin wr_data = rval & imm; c_nxt = 1'b0; wr_en = 1'b1; upd_z = 1'b1; end
          OP_OR:   begin wr_data = rval | imm; c_nxt = 1'b0; wr_en = 1'b1; upd_z = 1'b1; end
          OP_XOR:  begin wr_data = rval ^ imm; c_nxt = 1'b0; wr_en = 1'b1; upd_z = 1'b1; end
          OP_LDI:  begin wr_data = imm;   wr_en = 1'b1; end
          OP_IN:   begin wr_data = io_in; wr_en = 1'b1; end
          OP_OUT:  out_ld = 1'b1;
          OP_JMP:  pc_nxt = imm[PCW-1:0];
          OP_JZ:   if (flag_z) pc_nxt = imm[PCW-1:0];
          OP_JC:   if (flag_c) pc_nxt = imm[PCW-1:0];
          OP_ADDR: begin ext = {1'b0, rval} + {1'b0, sval}; wr_data = ext[DW-1:0]; c_nxt = ext[DW]; wr_en = 1'b1; upd_z = 1'b1; end
          OP_SHL:  begin wr_data = {rval[DW-2:0], 1'b0}; c_nxt = rval[DW-1]; wr_en = 1'b1; upd_z = 1'b1; end
          OP_SHR:  begin wr_data = {1'b0, rval[DW-1:1]}; c_nxt = rval[0];    wr_en = 1'b1; upd_z = 1'b1; end
          OP_NOP:  ;
          OP_HALT: begin state_nxt = S_HALT; pc_nxt = pc; end
          default: ;
        endcase
        if (upd_z) z_nxt = (wr_data == '0);
      end
      S_HALT:  ;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Architectural registers; imem_rd is registered so it is low throughout reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= '0;
      ir           <= '0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
      io_out       <= '0;
      io_out_valid <= 1'b0;
      halted       <= 1'b0;
      imem_rd      <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      pc           <= pc_nxt;
      flag_z       <= z_nxt;
      flag_c       <= c_nxt;
      io_out_valid <= out_ld;
      halted       <= (state_nxt == S_HALT);
      imem_rd      <= (state_nxt == S_FETCH);
      if (ir_ld)  ir             <= imem_data;
      if (out_ld) io_out         <= rval;
      if (wr_en)  regs[rd_idx]   <= wr_data;
    end
  end

endmodule

// File: doc/mcu_core_p.md
Name: mcu_core_p

Overview:
Parametrised multi-cycle microcontroller core: the successor to the single-cycle 4-opcode controller.
- Generalised in data width, register-file depth and program-counter width.
- Fetches instructions from external instruction memory over a valid handshake, executes a 16-opcode ISA with Z/C flags and conditional branches, and exchanges data through an I/O port.
- Sits between the instruction ROM/loader and the system I/O fabric.

Parameters:
DW, 8, data/register width in bits (>=4)
RAW, 4, register address width; register file has 2**RAW entries
PCW, 4, program counter width; program space 2**PCW words (PCW<=DW)
IW, 4+RAW+DW, instruction width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
imem_addr  output  PCW  fetch address
imem_rd  output  1  fetch request
imem_data  input  IW  instruction word {op[3:0], rd[RAW-1:0], imm[DW-1:0]}
imem_valid  input  1  imem_data valid this cycle
io_in  input  DW  input port, sampled by IN
io_out  output  DW  output port data
io_out_valid  output  1  one-cycle strobe per OUT
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow flag
halted  output  1  core stopped by HALT

Behaviour:
- Reset is asynchronous, active-high, on clk domain. While asserted:
  - pc=0, IR=0, all registers=0, flags=0.
  - io_out=0, io_out_valid=0, halted=0, imem_rd=0, state=FETCH.
  - Reset mid-instruction aborts the instruction; no partial writeback.
- FSM states FETCH, EXEC, HALT.
  - FETCH: imem_rd=1, imem_addr=pc. Holds until imem_valid=1, then IR<=imem_data and go to EXEC. imem_valid in any other state is ignored.
  - EXEC: one cycle. Register/flag/pc update at the end of the cycle; next state FETCH (HALT for op F).
  - Minimum 2 cycles per instruction; each wait cycle in FETCH adds 1.
- pc<=pc+1 (mod 2**PCW, wraps to 0) unless a taken jump loads imm[PCW-1:0].
- Opcodes (R=reg[rd], all results DW bits, truncated):
  - 0 ADD R=R+imm; C=carry out
  - 1 SUB R=R-imm; C=1 if R<imm (borrow)
  - 2 AND, 3 OR, 4 XOR with imm; C=0
  - 5 LDI R=imm; flags unchanged
  - 6 IN R=io_in sampled in EXEC; flags unchanged
  - 7 OUT io_out<=R, io_out_valid=1 for exactly the following cycle; io_out holds the value until the next OUT
  - 8 JMP; 9 JZ if Z=1; A JC if C=1. Not-taken branches fall through to pc+1.
  - B ADDR R=R+reg[imm[RAW-1:0]]; C=carry. If rd equals the source, the pre-update value is used (R+R).
  - C SHL R=R<<1, C=old msb; D SHR R=R>>1 (logical), C=old lsb
  - E NOP
  - F HALT
- Z=(result==0) after ops 0-4, B, C, D; other ops leave Z unchanged.
- Branches test flags as they stand at the start of EXEC, so a flag set by the previous instruction is visible.
- HALT: halted=1, imem_rd=0; pc and registers frozen. Only reset exits. io_out_valid stays 0.
- Unused imm bits are ignored. Register file is not externally visible except via OUT.

Test Plan:
- Reset: assert reset mid-EXEC of ADD r1,5 -> r1 stays 0, pc=0, all outputs 0; after release the first imem_addr=0 with imem_rd=1.
- Arithmetic/flags (DW=8): LDI r2,0xF0; ADD r2,0x20; OUT r2 -> io_out=0x10, C=1, Z=0, one-cycle io_out_valid. Then SUB r2,0x10 -> r2=0, Z=1, C=0.
- Branch: LDI r0,1; SUB r0,1; JZ 7 -> next imem_addr=7. Repeat with LDI r0,2 -> imem_addr=3 (fall-through).
- Handshake: hold imem_valid=0 for 3 cycles during FETCH -> imem_addr stable, no state change, instruction executes 1 cycle after valid.
- PC wrap (PCW=4): run NOPs from pc=14 -> addresses 14, 15, 0.
- Shift/HALT/param: SHL of 0x81 -> 0x02, C=1; HALT -> halted=1 and no further fetches for 10 cycles. Rerun ADD/OUT with DW=16, RAW=3: 0xFFFF+1 -> 0, C=1, Z=1.
